gumnut_ifetch: RTL and testbench
================================

Name: gumnut_ifetch

Overview:
Instruction fetch unit for the Gumnut core. It owns the 12-bit program counter and runs Wishbone-style read cycles on the 4096 x 18 instruction memory. Each fetched 18-bit word is delivered, with a one-cycle write strobe, to the instruction register/decoder, which is the consumer on the other side of this interface. It handles PC increment, control-flow redirects (including redirects that arrive mid-fetch) and bus timeout.

Parameters:
RESET_PC, 12'h000, PC value loaded on reset.
TIMEOUT, 15, wait-state cycles in WAIT before the fetch is aborted; range 1..255.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cen  input  1  core clock enable; when low, new fetch starts are suppressed
fetch_i  input  1  request a fetch at the current PC; level-sampled in IDLE
redirect_i  input  1  load the PC with redirect_addr_i (jump, branch, ret, int vector); 1-cycle pulse
redirect_addr_i  input  12  redirect target
inst_cyc_o  output  1  bus cycle active
inst_stb_o  output  1  bus strobe
inst_adr_o  output  12  instruction memory address
inst_dat_i  input  18  instruction read data
inst_ack_i  input  1  bus acknowledge
inst_o  output  18  instruction word to the IR inst input
ir_we_o  output  1  IR write enable; 1-cycle pulse, valid with inst_o
pc_o  output  12  current PC (address of the next fetch)
busy_o  output  1  high while the FSM is not in IDLE
err_o  output  1  1-cycle pulse on bus timeout

Behaviour:
- Reset (synchronous, priority over all inputs, any state): pc_o=RESET_PC, inst_o=0, ir_we_o=0, inst_cyc_o=inst_stb_o=0, inst_adr_o=0, busy_o=0, err_o=0, wait counter=0, redirect-pending flag=0, state=IDLE. Reset during WAIT drops cyc/stb at that edge, and a later ack is ignored.
- States: IDLE, WAIT, GAP.
- IDLE
  - If redirect_i is high, PC <= redirect_addr_i.
  - If cen && fetch_i: go to WAIT and drive cyc=stb=1. inst_adr_o = redirect_addr_i if redirect_i is high in the same cycle, else PC.
  - All outputs are registered. cyc/stb/adr become visible the cycle after the request.
- WAIT
  - cyc, stb and adr are held stable. The wait counter increments each cycle without ack.
  - cen has no effect; an in-flight cycle always completes.
  - ack && !pending && !redirect_i:
    - inst_o <= inst_dat_i; ir_we_o=1 for exactly the next cycle.
    - PC <= PC+1, modulo 2^12 (12'hFFF wraps to 12'h000).
    - Drop cyc/stb and go to IDLE.
  - redirect_i in WAIT (with or without ack in the same cycle):
    - Latch the target and set the pending flag; a later redirect overwrites the target.
    - On ack with pending set: discard the data, leave ir_we_o low, PC <= target, clear pending, drop cyc/stb, go to GAP.
    - Redirect and ack in the same cycle: redirect wins, the word is discarded, go to GAP with PC=target.
  - Wait counter reaches TIMEOUT without ack:
    - Drop cyc/stb, err_o=1 for one cycle, go to IDLE.
    - PC is unchanged, or takes the pending target if set; pending is cleared.
    - ack and timeout in the same cycle: ack wins.
- GAP: one cycle with cyc=stb=0, then re-issue automatically at the new PC and go to WAIT, regardless of fetch_i/cen. This implements back-to-back Wishbone cycle separation.
- busy_o = (state != IDLE).
- ir_we_o is never high in two consecutive cycles. inst_o holds its value until the next successful fetch.
- Minimum fetch latency: request cycle to ir_we_o high = 3 cycles with a zero-wait-state (same-cycle) ack.
- An ack while cyc is low is ignored.

Test Plan:
1. Basic fetch: reset, memory word 0x000 = 18'h2A5F3 with 1-wait ack, fetch_i pulse → adr=0x000 with cyc/stb, ir_we_o single pulse with inst_o=18'h2A5F3, pc_o=0x001, busy_o back to 0.
2. Sequential and wrap: redirect to 0xFFE, three fetches → adr 0xFFE, 0xFFF, 0x000. After the third fetch pc_o=0x001 and three ir_we_o pulses have occurred.
3. Redirect mid-fetch: fetch at 0x010, redirect_i=1 with addr 0x200 on cycle 1 of WAIT, ack 2 cycles later with 18'h3FFFF → no ir_we_o for that word, one GAP cycle, re-fetch adr=0x200. inst_o gets the word from 0x200 and pc_o=0x201.
4. Simultaneous events:
   - redirect_i and ack in the same cycle → word discarded, PC=target.
   - redirect_i and fetch_i in IDLE → first adr=redirect_addr_i.
   - ack on the cycle the timeout expires → fetch succeeds and err_o stays 0.
5. Timeout: TIMEOUT=15, memory never acks → cyc/stb drop after 15 wait cycles, err_o pulses once, pc_o unchanged, ir_we_o never asserted. A subsequent fetch with ack succeeds normally.
6. cen and reset: cen=0 with fetch_i=1 → no cycle starts. Dropping cen mid-WAIT → the cycle still completes with ir_we_o. Reset asserted in WAIT → cyc/stb=0 and pc_o=RESET_PC next cycle, and a late ack produces no ir_we_o.

Source files
------------

// File: rtl/gumnut_ifetch_if.sv
// gumnut_ifetch_if: Wishbone-style read bus between the fetch unit and instruction memory
interface gumnut_ifetch_if;
    logic        inst_cyc_o;
    logic        inst_stb_o;
    logic [11:0] inst_adr_o;
    logic [17:0] inst_dat_i;
    logic        inst_ack_i;
    modport master (output inst_cyc_o, inst_stb_o, inst_adr_o, input inst_dat_i, inst_ack_i);
    modport slave (input inst_cyc_o, inst_stb_o, inst_adr_o, output inst_dat_i, inst_ack_i);
endinterface

// File: rtl/gumnut_ifetch.sv
// gumnut_ifetch: Gumnut instruction fetch unit, owns the PC and runs read cycles on instruction memory
module gumnut_ifetch #(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   fetch_i,
    input  logic                   redirect_i,
    input  logic [11:0]            redirect_addr_i,
    gumnut_ifetch_if.master        bus,
    output logic [17:0]            inst_o,
    output logic                   ir_we_o,
    output logic [11:0]            pc_o,
    output logic                   busy_o,
    output logic                   err_o
);
    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t      state, state_n;
    logic        cyc, cyc_n, we_n, err_n, pend, pend_n;
    logic [11:0] adr, adr_n, pc_n, tgt, tgt_n;
    logic [17:0] inst_n;
    logic [7:0]  cnt, cnt_n;
    assign bus.inst_cyc_o = cyc;
    assign bus.inst_stb_o = cyc;
    assign bus.inst_adr_o = adr;
    assign busy_o         = state != IDLE;
    always_comb begin
        state_n = state;
        pc_n    = pc_o;
        adr_n   = adr;
        cyc_n   = cyc;
        inst_n  = inst_o;
        we_n    = 1'b0;
        err_n   = 1'b0;
        cnt_n   = cnt;
        pend_n  = pend;
        tgt_n   = tgt;
        case (state)
            IDLE: begin
                pc_n = redirect_i ? redirect_addr_i : pc_o;
                if (cen && fetch_i) begin
                    state_n = WAIT;
                    cyc_n   = 1'b1;
                    adr_n   = pc_n;
                    cnt_n   = '0;
                end
            end
            WAIT: begin
                // ack beats timeout; a redirect seen during the cycle discards the word
                if (bus.inst_ack_i) begin
                    cyc_n   = 1'b0;
                    pend_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = (redirect_i || pend) ? GAP : IDLE;
                    pc_n    = redirect_i ? redirect_addr_i : pend ? tgt : pc_o + 12'd1;
                    we_n    = !(redirect_i || pend);
                    inst_n  = we_n ? bus.inst_dat_i : inst_o;
                end else if (cnt == LAST) begin
                    cyc_n   = 1'b0;
                    pend_n  = 1'b0;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                    pc_n    = redirect_i ? redirect_addr_i : pend ? tgt : pc_o;
                end else begin
                    cnt_n  = cnt + 8'd1;
                    pend_n = pend || redirect_i;
                    tgt_n  = redirect_i ? redirect_addr_i : tgt;
                end
            end
            GAP: begin
                state_n = WAIT;
                cyc_n   = 1'b1;
                pc_n    = redirect_i ? redirect_addr_i : pc_o;
                adr_n   = pc_n;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc_o    <= RESET_PC;
            adr     <= '0;
            cyc     <= 1'b0;
            inst_o  <= '0;
            ir_we_o <= 1'b0;
            err_o   <= 1'b0;
            cnt     <= '0;
            pend    <= 1'b0;
            tgt     <= '0;
        end else begin
            state   <= state_n;
            pc_o    <= pc_n;
            adr     <= adr_n;
            cyc     <= cyc_n;
            inst_o  <= inst_n;
            ir_we_o <= we_n;
            err_o   <= err_n;
            cnt     <= cnt_n;
            pend    <= pend_n;
            tgt     <= tgt_n;
        end
    end
endmodule

// File: tb/tb_gumnut_ifetch.sv
// tb_gumnut_ifetch: vector table, corner sequences and randomized transactions against a transaction-level model
module tb_gumnut_ifetch;
    localparam int TO    = 15;
    localparam int NEVER = 1000;
    typedef struct {
        bit          rf;
        logic [11:0] ra;
        int          ws;
        int          r;
        logic [11:0] ta;
        logic [11:0] pc;
        logic [11:0] a0;
        logic [11:0] a1;
        int          na;
        int          we;
        int          err;
        int          cyc;
    } vec_t;
    logic        clk = 0, rst = 1, cen = 1, fetch_i = 0, redirect_i = 0;
    logic [11:0] redirect_addr_i = 0;
    logic [17:0] inst_o;
    logic        ir_we_o, busy_o, err_o;
    logic [11:0] pc_o;
    logic [17:0] mem [4096];
    int          tests = 0, fails = 0;
    int          ws = NEVER, wcnt = 0, we_cnt = 0, err_cnt = 0, cyc_cnt = 0;
    logic        man_ack = 0, prev_we = 0, prev_cyc = 0;
    logic [11:0] prev_adr = 0, m_pc = 0;
    logic [17:0] m_inst = 0;
    logic [11:0] adrq [$];
    vec_t        tbl [10];
    gumnut_ifetch_if bus ();
    gumnut_ifetch #(.RESET_PC(12'h000), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cen(cen), .fetch_i(fetch_i), .redirect_i(redirect_i),
        .redirect_addr_i(redirect_addr_i), .bus(bus), .inst_o(inst_o), .ir_we_o(ir_we_o),
        .pc_o(pc_o), .busy_o(busy_o), .err_o(err_o)
    );
    initial forever #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // advance to the next negedge, observe the bus, then drive the memory response for this cycle
    task automatic tick();
        @(negedge clk);
        if (ir_we_o) begin
            we_cnt++;
            chk("we_back_to_back", {31'b0, prev_we}, 0);
        end
        if (err_o) err_cnt++;
        if (bus.inst_cyc_o || bus.inst_stb_o) chk("stb_eq_cyc", {31'b0, bus.inst_stb_o}, {31'b0, bus.inst_cyc_o});
        if (bus.inst_cyc_o) cyc_cnt++;
        if (bus.inst_cyc_o && !prev_cyc) adrq.push_back(bus.inst_adr_o);
        if (bus.inst_cyc_o && prev_cyc) chk("adr_stable", {20'b0, bus.inst_adr_o}, {20'b0, prev_adr});
        prev_we  = ir_we_o;
        prev_cyc = bus.inst_cyc_o;
        prev_adr = bus.inst_adr_o;
        bus.inst_ack_i = (bus.inst_cyc_o && wcnt == ws) || man_ack;
        bus.inst_dat_i = mem[bus.inst_adr_o];
        wcnt = bus.inst_cyc_o ? wcnt + 1 : 0;
    endtask
    function automatic vec_t model(bit rf, logic [11:0] ra, int w, int r, logic [11:0] ta, logic [11:0] pc);
        vec_t v;
        v = '{rf, ra, w, r, ta, 12'h0, rf ? ra : pc, 12'h0, 1, 1, 0, w + 1};
        if (w >= TO) begin
            v.we  = 0;
            v.err = 1;
            v.cyc = TO;
            v.pc  = r >= 0 ? ta : v.a0;
        end else if (r >= 0) begin
            v.na  = 2;
            v.a1  = ta;
            v.pc  = ta + 12'd1;
            v.cyc = 2 * (w + 1);
        end else v.pc = v.a0 + 12'd1;
        return v;
    endfunction
    task automatic do_vec(input vec_t v, input string tag);
        int k;
        ws = v.ws;
        we_cnt = 0; err_cnt = 0; cyc_cnt = 0;
        adrq.delete();
        fetch_i = 1; redirect_i = v.rf; redirect_addr_i = v.ra;
        tick();
        fetch_i = 0;
        k = 0;
        while (busy_o && k < 100) begin
            redirect_i = (k == v.r);
            if (k == v.r) redirect_addr_i = v.ta;
            tick();
            k++;
        end
        redirect_i = 0;
        chk({tag, " done"}, {31'b0, busy_o}, 0);
        chk({tag, " pc"}, {20'b0, pc_o}, {20'b0, v.pc});
        chk({tag, " we"}, we_cnt, v.we);
        chk({tag, " err"}, err_cnt, v.err);
        chk({tag, " cyc_cycles"}, cyc_cnt, v.cyc);
        chk({tag, " n_adr"}, adrq.size(), v.na);
        if (adrq.size() > 0) chk({tag, " adr0"}, {20'b0, adrq[0]}, {20'b0, v.a0});
        if (adrq.size() > 1 && v.na > 1) chk({tag, " adr1"}, {20'b0, adrq[1]}, {20'b0, v.a1});
        if (v.we != 0) m_inst = mem[v.na == 2 ? v.a1 : v.a0];
        chk({tag, " inst"}, {14'b0, inst_o}, {14'b0, m_inst});
        m_pc = v.pc;
    endtask
    initial begin
        bit          rf;
        int          w, r;
        logic [11:0] ra, ta, a;
        bus.inst_ack_i = 0;
        bus.inst_dat_i = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 18'($urandom);
        mem[12'h000] = 18'h2A5F3;
        mem[12'h010] = 18'h3FFFF;
        tbl[0] = '{0, 12'h000, 1,     -1, 12'h000, 12'h001, 12'h000, 12'h000, 1, 1, 0, 2};
        tbl[1] = '{1, 12'hFFE, 0,     -1, 12'h000, 12'hFFF, 12'hFFE, 12'h000, 1, 1, 0, 1};
        tbl[2] = '{0, 12'h000, 2,     -1, 12'h000, 12'h000, 12'hFFF, 12'h000, 1, 1, 0, 3};
        tbl[3] = '{0, 12'h000, 0,     -1, 12'h000, 12'h001, 12'h000, 12'h000, 1, 1, 0, 1};
        tbl[4] = '{1, 12'h010, 3,      1, 12'h200, 12'h201, 12'h010, 12'h200, 2, 1, 0, 8};
        tbl[5] = '{0, 12'h000, 2,      2, 12'hABC, 12'hABD, 12'h201, 12'hABC, 2, 1, 0, 6};
        tbl[6] = '{0, 12'h000, NEVER, -1, 12'h000, 12'hABD, 12'hABD, 12'h000, 1, 0, 1, 15};
        tbl[7] = '{0, 12'h000, 14,    -1, 12'h000, 12'hABE, 12'hABD, 12'h000, 1, 1, 0, 15};
        tbl[8] = '{0, 12'h000, NEVER,  5, 12'h555, 12'h555, 12'hABE, 12'h000, 1, 0, 1, 15};
        tbl[9] = '{0, 12'h000, 0,     -1, 12'h000, 12'h556, 12'h555, 12'h000, 1, 1, 0, 1};
        repeat (3) tick();
        rst = 0;
        tick();
        chk("rst pc", {20'b0, pc_o}, 0);
        chk("rst cyc", {31'b0, bus.inst_cyc_o}, 0);
        chk("rst stb", {31'b0, bus.inst_stb_o}, 0);
        chk("rst adr", {20'b0, bus.inst_adr_o}, 0);
        chk("rst inst", {14'b0, inst_o}, 0);
        chk("rst we", {31'b0, ir_we_o}, 0);
        chk("rst busy", {31'b0, busy_o}, 0);
        chk("rst err", {31'b0, err_o}, 0);
        for (int i = 0; i < 10; i++) do_vec(tbl[i], $sformatf("vec%0d", i));
        // zero-wait fetch: request, wait cycle, then the write strobe
        ws = 0; we_cnt = 0;
        fetch_i = 1;
        tick();
        fetch_i = 0;
        chk("lat busy", {31'b0, busy_o}, 1);
        chk("lat we_early", {31'b0, ir_we_o}, 0);
        tick();
        chk("lat we", {31'b0, ir_we_o}, 1);
        chk("lat inst", {14'b0, inst_o}, {14'b0, mem[12'h556]});
        chk("lat pc", {20'b0, pc_o}, 12'h557);
        m_inst = mem[12'h556];
        ws = 3; we_cnt = 0;
        fetch_i = 1;
        tick();
        fetch_i = 0; cen = 0;
        for (int k = 0; k < 20 && busy_o; k++) tick();
        chk("cen_drop we", we_cnt, 1);
        chk("cen_drop pc", {20'b0, pc_o}, 12'h558);
        m_inst = mem[12'h557];
        cyc_cnt = 0;
        fetch_i = 1;
        repeat (3) tick();
        fetch_i = 0;
        chk("cen_low busy", {31'b0, busy_o}, 0);
        chk("cen_low cyc", cyc_cnt, 0);
        cen = 1;
        redirect_i = 1; redirect_addr_i = 12'h123;
        tick();
        redirect_i = 0;
        chk("idle_redirect pc", {20'b0, pc_o}, 12'h123);
        chk("idle_redirect busy", {31'b0, busy_o}, 0);
        m_pc = 12'h123;
        for (int i = 0; i < 40; i++) begin
            rf = $urandom_range(0, 3) == 0;
            ra = 12'($urandom);
            ta = 12'($urandom);
            w  = $urandom_range(0, 4) == 0 ? NEVER : int'($urandom_range(0, TO - 1));
            r  = $urandom_range(0, 2) != 0 ? -1 : w == NEVER ? int'($urandom_range(0, TO - 2)) : int'($urandom_range(0, w));
            do_vec(model(rf, ra, w, r, ta, m_pc), $sformatf("rnd%0d", i));
        end
        a = m_pc;
        ws = NEVER; we_cnt = 0;
        fetch_i = 1;
        tick();
        fetch_i = 0;
        tick();
        chk("rst_wait cyc_before", {31'b0, bus.inst_cyc_o}, 1);
        chk("rst_wait adr_before", {20'b0, bus.inst_adr_o}, {20'b0, a});
        rst = 1;
        tick();
        rst = 0;
        chk("rst_wait cyc", {31'b0, bus.inst_cyc_o}, 0);
        chk("rst_wait stb", {31'b0, bus.inst_stb_o}, 0);
        chk("rst_wait pc", {20'b0, pc_o}, 0);
        chk("rst_wait busy", {31'b0, busy_o}, 0);
        man_ack = 1;
        repeat (3) tick();
        man_ack = 0;
        tick();
        chk("late_ack we", we_cnt, 0);
        chk("late_ack busy", {31'b0, busy_o}, 0);
        chk("late_ack inst", {14'b0, inst_o}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
